apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Two-requester APB arbiter/sequencer that shares the single 64-bit APB bus between two internal command sources. It round-robins the requesters, drives the APB SETUP/ACCESS phases, decodes one address bit into the two slave selects PSEL1/PSEL2, absorbs PREADY wait states, and returns read data and PSLVERR to the winning requester. It sits between the command sources and the APB slaves, replacing direct testbench-style driving of PSEL/PENABLE.

## Interface
- ADDR_W, 64, APB address width
- DATA_W, 64, APB data width
- SEL_BIT, 12, address bit that selects the slave: 0 → PSEL1, 1 → PSEL2
- TIMEOUT, 16, max ACCESS cycles with PREADY low; used only with APB_ARB_TIMEOUT_EN

- PCLK  in  1  clock; all state on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester command valid; bit n = requester n
- req_ready  out  2  one-hot command accept; valid&ready at an edge = accepted
- req_write  in  2  per-requester 1 = write, 0 = read
- req_addr  in  2*ADDR_W  packed addresses; requester n at [n*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  packed write data, same packing
- rsp_valid  out  2  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  completion error, valid with rsp_valid
- PSEL1, PSEL2  out  1 each  APB slave selects
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- FSM: IDLE, SETUP, ACCESS. Reset → IDLE.
- Arbitration: round-robin pointer `last`; on a tie, the requester not granted last wins; after reset requester 0 wins the first tie. A single valid requester always wins.
- req_ready (combinational) is asserted to the winner only in IDLE, or in ACCESS on the cycle PREADY=1 (or timeout). On acceptance, latch write/addr/wdata and grant index → SETUP.
- SETUP: PSELx=1 (x from latched addr[SEL_BIT]), PENABLE=0, PADDR/PWRITE/PWDATA from latch (PWDATA=0 on reads) → ACCESS.
- ACCESS: PSELx=1, PENABLE=1, outputs held stable; stay while PREADY=0. On PREADY=1, capture PRDATA (reads) and PSLVERR, update `last`, then go to SETUP if a new command is accepted in the same cycle, else IDLE.
- In IDLE, all APB outputs are 0.
- Requester must hold req_* stable while req_valid=1 and not yet accepted. Both requesters may have one command pending.

## Timing
- Reset values: all outputs 0, FSM IDLE, `last` = 1 (requester 0 favoured).
- PRESETn low at any point, including mid-ACCESS: APB outputs drop to 0 asynchronously, the in-flight transfer is discarded, and no rsp_valid is issued.
- Accept at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → with zero wait states, rsp_valid/rsp_rdata/rsp_err are registered and visible in cycle 3 for one cycle.
- Each PREADY-low cycle adds one ACCESS cycle.
- Back-to-back: a command accepted on the completion cycle enters SETUP next cycle with no IDLE gap, giving 2 cycles per zero-wait transfer.
- rsp_rdata and rsp_err hold their value until the next completion.

## Configuration
- APB_ARB_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments on each PREADY=0 cycle. When the count reaches TIMEOUT, the transfer terminates as if PREADY=1, with rsp_err=1 and rsp_rdata=0, and the FSM leaves ACCESS.
- Not defined: no counter; ACCESS waits indefinitely; TIMEOUT is ignored.

## Test plan
- Req0 write addr 0x34, wdata 0x45, PREADY=1 → cycle 1: PSEL1=1, PENABLE=0, PWRITE=1, PADDR=0x34, PWDATA=0x45; cycle 2: PENABLE=1; cycle 3: rsp_valid=2'b01, rsp_err=0.
- Req1 read addr 0x1034, PREADY low 3 cycles, then high with PRDATA=0xDEAD → PSEL2 asserted, ACCESS lasts 4 cycles, rsp_valid=2'b10, rsp_rdata=0xDEAD.
- Both requesters continuously valid, PREADY=1 → grant order 0,1,0,1, transfers every 2 cycles, PSEL never drops between transfers.
- Req0 read, PREADY=1, PSLVERR=1 → rsp_err=1 with rsp_valid=2'b01; the next transfer reports rsp_err=0.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE=0 immediately, no rsp_valid; after release with both requesters valid, requester 0 is granted first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=16, PREADY held 0 → ACCESS ends after 16 cycles, rsp_err=1, rsp_rdata=0; without the macro → still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sequencer sharing one APB bus between two command sources.
// Optional ACCESS-phase timeout is built in when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SEL_BIT = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL1,
  output logic                PSEL2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_last;
  logic                r_gnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic w_timeout;
  logic w_done;
  logic w_accept;
  logic w_last_eff;
  logic w_win;
  logic w_active;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] r_to_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_to_cnt <= '0;
    end else if (r_state == StSetup) begin
      r_to_cnt <= '0;
    end else if (r_state == StAccess && !PREADY) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Fires on the stalled cycle whose increment would bring the count to TIMEOUT.
  assign w_timeout = (r_state == StAccess) && !PREADY && (r_to_cnt == CntW'(TIMEOUT - 1));
`else
  // TIMEOUT has no effect without the timeout feature.
  assign w_timeout = 1'b0 & (TIMEOUT != 32'd0);
`endif

  assign w_done = (r_state == StAccess) && (PREADY || w_timeout);

  // On a completion cycle the finishing grant counts as the most recent one.
  assign w_last_eff = (r_state == StAccess) ? r_gnt : r_last;
  assign w_win      = (&req_valid) ? ~w_last_eff : req_valid[1];
  assign w_accept   = ((r_state == StIdle) || w_done) && (|req_valid);
  assign req_ready  = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StSetup;
      StSetup:  w_state_next = StAccess;
      StAccess: if (w_done) w_state_next = w_accept ? StSetup : StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_done) begin
        r_last <= r_gnt;
      end
      if (w_accept) begin
        r_gnt   <= w_win;
        r_write <= req_write[w_win];
        r_addr  <= w_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        r_wdata <= w_win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
      r_rsp_rdata <= (r_write || w_timeout) ? '0 : PRDATA;
      r_rsp_err   <= w_timeout | PSLVERR;
    end else begin
      r_rsp_valid <= 2'b00;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // APB outputs decode from registered state so reset clears them immediately.
  assign w_active = (r_state != StIdle);
  assign PSEL1    = w_active && !r_addr[SEL_BIT];
  assign PSEL2    = w_active && r_addr[SEL_BIT];
  assign PENABLE  = (r_state == StAccess);
  assign PWRITE   = w_active && r_write;
  assign PADDR    = w_active ? r_addr : '0;
  assign PWDATA   = (w_active && r_write) ? r_wdata : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter against a transaction-level reference model.
module tb_apb_req_arbiter;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_rdata;
  logic         rsp_err;
  logic         PSEL1, PSEL2, PENABLE, PWRITE;
  logic [63:0]  PADDR, PWDATA, PRDATA;
  logic         PREADY, PSLVERR;

  apb_req_arbiter dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: one pending command each.
  bit          pend[2];
  bit          pw[2];
  logic [63:0] pa[2];
  logic [63:0] pd[2];

  // Transfer in flight: busy, in access phase, owner, command, stall count.
  bit          m_busy, m_acc, m_w;
  int          m_idx, m_wait;
  int          m_last_grant;
  logic [63:0] m_a, m_d;
  // Registered response expectations.
  logic [1:0]  e_rsp_valid;
  logic [63:0] e_rdata;
  bit          e_err;
  int          n_timeouts = 0;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_w = 0; m_idx = 0; m_wait = 0;
    m_last_grant = 1; m_a = '0; m_d = '0;
    e_rsp_valid = 2'b00; e_rdata = '0; e_err = 0;
  endtask

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_write = {pw[1], pw[0]};
    req_addr  = {pa[1], pa[0]};
    req_wdata = {pd[1], pd[0]};
  endtask

  task automatic new_cmd(input int i);
    pend[i] = 1;
    pw[i]   = 1'($urandom_range(1));
    pa[i]   = {$urandom, $urandom};
    pd[i]   = {$urandom, $urandom};
  endtask

  // One clock cycle: drive at edge+1, check at edge+2, advance model, wait for next edge+1.
  task automatic step(input int p_new, input int p_ready);
    bit done, to, any;
    int win;
    logic [1:0] exp_ready;
    for (int i = 0; i < 2; i++)
      if (!pend[i] && int'($urandom_range(99)) < p_new) new_cmd(i);
    drive_reqs();
    PREADY  = int'($urandom_range(99)) < p_ready;
    PRDATA  = {$urandom, $urandom};
    PSLVERR = ($urandom_range(3) == 0);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    check("rsp_rdata", rsp_rdata, e_rdata);
    check("rsp_err", 64'(rsp_err), 64'(e_err));
    check("psel1", 64'(PSEL1), 64'(m_busy && !m_a[12]));
    check("psel2", 64'(PSEL2), 64'(m_busy && m_a[12]));
    check("penable", 64'(PENABLE), 64'(m_busy && m_acc));
    check("pwrite", 64'(PWRITE), 64'(m_busy && m_w));
    check("paddr", PADDR, m_busy ? m_a : 64'd0);
    check("pwdata", PWDATA, (m_busy && m_w) ? m_d : 64'd0);

    to = 0;
`ifdef APB_ARB_TIMEOUT_EN
    to = m_busy && m_acc && !PREADY && (m_wait == 15);
`endif
    done = m_busy && m_acc && (PREADY || to);
    any  = pend[0] || pend[1];
    if (pend[0] && pend[1]) win = 1 - m_last_grant;
    else                    win = pend[1] ? 1 : 0;
    exp_ready = ((!m_busy || done) && any) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", 64'(req_ready), 64'(exp_ready));

    if (done) begin
      e_rsp_valid = (m_idx == 1) ? 2'b10 : 2'b01;
      e_rdata     = (m_w || to) ? 64'd0 : PRDATA;
      e_err       = to || PSLVERR;
      if (to) n_timeouts++;
    end else begin
      e_rsp_valid = 2'b00;
    end

    if ((!m_busy || done) && any) begin
      m_busy = 1; m_acc = 0; m_idx = win; m_last_grant = win;
      m_w = pw[win]; m_a = pa[win]; m_d = pw[win] ? pd[win] : pd[win];
      pend[win] = 0;
    end else if (done) begin
      m_busy = 0; m_acc = 0;
    end else if (m_busy && !m_acc) begin
      m_acc = 1; m_wait = 0;
    end else if (m_busy && m_acc && !PREADY) begin
      m_wait++;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || pend[0] || pend[1]) && n < 60) begin
      step(0, 100);
      n++;
    end
    if (m_busy || pend[0] || pend[1]) check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    PRESETn = 1'b0;
    PREADY = 0; PSLVERR = 0; PRDATA = '0;
    pend[0] = 0; pend[1] = 0;
    pw[0] = 0; pw[1] = 0; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    drive_reqs();
    model_reset();
    #2;
    check("rst_psel", 64'({PSEL2, PSEL1}), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_paddr", PADDR, 64'd0);
    check("rst_rsp", 64'({rsp_err, rsp_valid}), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;

    // Directed first command: requester 0 write 0x34 / 0x45.
    pend[0] = 1; pw[0] = 1; pa[0] = 64'h34; pd[0] = 64'h45;
    step(0, 100);
    step(0, 100);
    step(0, 100);
    step(0, 100);

    repeat (3000) step(60, 60);
    repeat (400)  step(100, 100);
    drain();

    // Reset during ACCESS discards the transfer and restores requester-0 priority.
    pend[0] = 1; pw[0] = 0; pa[0] = 64'h1034; pd[0] = '0;
    step(0, 0);
    step(0, 0);
    PREADY = 1'b0;
    #1;
    check("mid_penable_before", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", 64'({PSEL2, PSEL1}), 64'd0);
    check("mid_rst_penable", 64'(PENABLE), 64'd0);
    @(posedge PCLK);
    #1;
    check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    model_reset();
    new_cmd(0);
    new_cmd(1);
    drive_reqs();
    PRESETn = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b01);
    repeat (20) step(0, 100);
    drain();

    // Permanent stall.
    new_cmd(0);
    repeat (103) step(0, 0);
`ifdef APB_ARB_TIMEOUT_EN
    check("timeout_seen", 64'(n_timeouts > 0), 64'd1);
`else
    check("stall_penable", 64'(PENABLE), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
